// File: rtl/tmu2_texfetch_if.sv
// ============================================================================
// tmu2_texfetch_if: token, FML read and texel-cache fill buses of the texel fetch unit.
// Rev 1.0
// ============================================================================
`default_nettype none

interface tmu2_texfetch_if #(
   parameter int FML_DEPTH = 26
);
   localparam int c_AW = FML_DEPTH - 5;

   logic              pipe_stb_i;
   logic              pipe_ack_o;
   logic [c_AW-1:0]   tadra;
   logic [c_AW-1:0]   tadrb;
   logic [c_AW-1:0]   tadrc;
   logic [c_AW-1:0]   tadrd;
   logic              miss_a;
   logic              miss_b;
   logic              miss_c;
   logic              miss_d;

   logic [FML_DEPTH-1:0] fml_adr;
   logic              fml_stb;
   logic              fml_ack;
   logic [63:0]       fml_di;

   logic              fill_stb_o;
   logic              fill_ack_i;
   logic [c_AW-1:0]   fill_adr;
   logic [255:0]      fill_dat;

   // Slave is the fetch unit itself; master is the surrounding pipeline/memory side.
   modport slave (
      input  pipe_stb_i, tadra, tadrb, tadrc, tadrd, miss_a, miss_b, miss_c, miss_d,
      input  fml_ack, fml_di, fill_ack_i,
      output pipe_ack_o, fml_adr, fml_stb, fill_stb_o, fill_adr, fill_dat
   );

   modport master (
      output pipe_stb_i, tadra, tadrb, tadrc, tadrd, miss_a, miss_b, miss_c, miss_d,
      output fml_ack, fml_di, fill_ack_i,
      input  pipe_ack_o, fml_adr, fml_stb, fill_stb_o, fill_adr, fill_dat
   );
endinterface

`default_nettype wire

// File: rtl/tmu2_texfetch.sv
// ============================================================================
// tmu2_texfetch: fetches missed texel bursts over FML, one burst per distinct address.
// Rev 1.0
// ============================================================================
`default_nettype none

module tmu2_texfetch #(
   parameter int FML_DEPTH = 26
) (
   input  wire logic      sys_clk,
   input  wire logic      sys_rst_n,
   output logic           busy,
   tmu2_texfetch_if.slave bus
);
   localparam int c_AW = FML_DEPTH - 5;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_DATA = 2'd2,
      S_OUT  = 2'd3
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic [c_AW-1:0]   r_adr [4];
   logic [3:0]        r_pend;
   logic [1:0]        r_beat;
   logic [c_AW-1:0]   r_fill_adr;
   logic [255:0]      r_fill_dat;

   logic              w_pa, w_pb, w_pc, w_pd;
   logic [3:0]        w_pend;
   logic [1:0]        w_sel;
   logic              w_accept;
   logic              w_fml_take;

   // A later slot is suppressed only when it matches a slot that is itself pending.
   assign w_pa = bus.miss_a;
   assign w_pb = bus.miss_b & ~(w_pa & (bus.tadrb == bus.tadra));
   assign w_pc = bus.miss_c & ~(w_pa & (bus.tadrc == bus.tadra))
                            & ~(w_pb & (bus.tadrc == bus.tadrb));
   assign w_pd = bus.miss_d & ~(w_pa & (bus.tadrd == bus.tadra))
                            & ~(w_pb & (bus.tadrd == bus.tadrb))
                            & ~(w_pc & (bus.tadrd == bus.tadrc));
   assign w_pend = {w_pd, w_pc, w_pb, w_pa};

   assign w_sel = r_pend[0] ? 2'd0 :
                  r_pend[1] ? 2'd1 :
                  r_pend[2] ? 2'd2 : 2'd3;

   assign w_accept   = (r_state == S_IDLE) & bus.pipe_stb_i;
   assign w_fml_take = (r_state == S_REQ) & bus.fml_ack;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_accept && (w_pend != 4'd0)) w_next = S_REQ;
         S_REQ:   if (bus.fml_ack) w_next = S_DATA;
         S_DATA:  if (r_beat == 2'd3) w_next = S_OUT;
         S_OUT:   if (bus.fill_ack_i) w_next = (r_pend != 4'd0) ? S_REQ : S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         for (int i = 0; i < 4; i++) r_adr[i] <= '0;
         r_pend     <= '0;
         r_beat     <= '0;
         r_fill_adr <= '0;
         r_fill_dat <= '0;
      end else begin
         if (w_accept) begin
            r_adr[0] <= bus.tadra;
            r_adr[1] <= bus.tadrb;
            r_adr[2] <= bus.tadrc;
            r_adr[3] <= bus.tadrd;
            r_pend   <= w_pend;
         end
         if (w_fml_take) begin
            r_pend[w_sel] <= 1'b0;
            r_beat        <= 2'd0;
            r_fill_adr    <= r_adr[w_sel];
         end
         // Shift in beats so beat 0 ends up in the top 64 bits.
         if (r_state == S_DATA) begin
            r_fill_dat <= {r_fill_dat[191:0], bus.fml_di};
            r_beat     <= r_beat + 2'd1;
         end
      end
   end

   assign busy           = (r_state != S_IDLE);
   assign bus.pipe_ack_o = (r_state == S_IDLE) & sys_rst_n;
   assign bus.fml_stb    = (r_state == S_REQ);
   assign bus.fml_adr    = (r_state == S_REQ) ? {r_adr[w_sel], 5'b0} : '0;
   assign bus.fill_stb_o = (r_state == S_OUT);
   assign bus.fill_adr   = r_fill_adr;
   assign bus.fill_dat   = r_fill_dat;

endmodule

`default_nettype wire

// File: tb/tb_tmu2_texfetch.sv
// ============================================================================
// tb_tmu2_texfetch: directed vector table plus hand-written corner sequences.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_tmu2_texfetch;
   localparam int FML_DEPTH = 26;
   localparam int AW        = FML_DEPTH - 5;

   typedef struct {
      logic [AW-1:0]        a, b, c, d;
      logic [3:0]           m;
      int                   n;
      logic [3:0][AW-1:0]   e;
   } vec_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic busy;
   int   checks = 0;
   int   errors = 0;
   vec_t vecs [7];

   always #5 clk = ~clk;

   tmu2_texfetch_if #(.FML_DEPTH(FML_DEPTH)) bus ();

   tmu2_texfetch #(.FML_DEPTH(FML_DEPTH)) dut (
      .sys_clk   (clk),
      .sys_rst_n (rst_n),
      .busy      (busy),
      .bus       (bus.slave)
   );

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic vec_t mkv(input logic [AW-1:0] a, b, c, d, input logic [3:0] m,
                                input int n, input logic [AW-1:0] e0, e1, e2, e3);
      vec_t v;
      v.a = a; v.b = b; v.c = c; v.d = d; v.m = m; v.n = n;
      v.e[0] = e0; v.e[1] = e1; v.e[2] = e2; v.e[3] = e3;
      return v;
   endfunction

   function automatic logic [3:0][63:0] mk_beats(input logic [AW-1:0] adr);
      logic [3:0][63:0] r;
      for (int k = 0; k < 4; k++) r[k] = {32'(adr), 32'(k + 1)};
      return r;
   endfunction

   // Called at a negedge with the unit idle; returns at the negedge after acceptance.
   task automatic send_token(input logic [AW-1:0] a, b, c, d, input logic [3:0] m);
      chk("pipe_ack_idle", bus.pipe_ack_o, 1);
      bus.pipe_stb_i = 1'b1;
      bus.tadra = a; bus.tadrb = b; bus.tadrc = c; bus.tadrd = d;
      bus.miss_a = m[0]; bus.miss_b = m[1]; bus.miss_c = m[2]; bus.miss_d = m[3];
      @(negedge clk);
      bus.pipe_stb_i = 1'b0;
   endtask

   task automatic do_burst(input logic [AW-1:0] adr, input logic [3:0][63:0] beats,
                           input int fml_hold, input int fill_hold);
      logic [255:0] expd;
      expd = {beats[0], beats[1], beats[2], beats[3]};
      chk("fml_stb", bus.fml_stb, 1);
      chk("fml_adr", bus.fml_adr, {adr, 5'b0});
      chk("busy_req", busy, 1);
      for (int i = 0; i < fml_hold; i++) begin
         @(negedge clk);
         chk("fml_stb_hold", bus.fml_stb, 1);
         chk("fml_adr_hold", bus.fml_adr, {adr, 5'b0});
         chk("pipe_ack_busy", bus.pipe_ack_o, 0);
      end
      bus.fml_ack = 1'b1;
      @(negedge clk);
      bus.fml_ack = 1'b0;
      chk("fml_stb_drop", bus.fml_stb, 0);
      for (int k = 0; k < 4; k++) begin
         bus.fml_di = beats[k];
         @(negedge clk);
      end
      bus.fml_di = '0;
      chk("fill_stb", bus.fill_stb_o, 1);
      chk("fill_adr", bus.fill_adr, adr);
      chk("fill_dat", bus.fill_dat, expd);
      chk("fml_stb_in_out", bus.fml_stb, 0);
      for (int i = 0; i < fill_hold; i++) begin
         @(negedge clk);
         chk("fill_stb_hold", bus.fill_stb_o, 1);
         chk("fill_dat_hold", bus.fill_dat, expd);
         chk("fill_adr_hold", bus.fill_adr, adr);
         chk("fml_stb_hold0", bus.fml_stb, 0);
      end
      bus.fill_ack_i = 1'b1;
      @(negedge clk);
      bus.fill_ack_i = 1'b0;
   endtask

   task automatic check_idle(input string tag);
      chk({tag, "_pipe_ack"}, bus.pipe_ack_o, 1);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_fml_stb"}, bus.fml_stb, 0);
      chk({tag, "_fill_stb"}, bus.fill_stb_o, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0][63:0] b4;

      bus.pipe_stb_i = 1'b0;
      bus.tadra = '0; bus.tadrb = '0; bus.tadrc = '0; bus.tadrd = '0;
      bus.miss_a = 1'b0; bus.miss_b = 1'b0; bus.miss_c = 1'b0; bus.miss_d = 1'b0;
      bus.fml_ack = 1'b0; bus.fml_di = '0; bus.fill_ack_i = 1'b0;

      vecs[0] = mkv(21'h12345, 21'h0, 21'h0, 21'h0, 4'b0001, 1, 21'h12345, 21'h0, 21'h0, 21'h0);
      vecs[1] = mkv(21'h10, 21'h10, 21'h20, 21'h10, 4'b1111, 2, 21'h10, 21'h20, 21'h0, 21'h0);
      vecs[2] = mkv(21'h5, 21'h6, 21'h7, 21'h8, 4'b0000, 0, 21'h0, 21'h0, 21'h0, 21'h0);
      vecs[3] = mkv(21'h55, 21'h55, 21'h3, 21'h55, 4'b1010, 1, 21'h55, 21'h0, 21'h0, 21'h0);
      vecs[4] = mkv(21'h1, 21'h2, 21'h3, 21'h4, 4'b1111, 4, 21'h1, 21'h2, 21'h3, 21'h4);
      vecs[5] = mkv(21'h7, 21'h0, 21'h7, 21'h1FFFFF, 4'b1100, 2, 21'h7, 21'h1FFFFF, 21'h0, 21'h0);
      vecs[6] = mkv(21'h1, 21'h2, 21'h9, 21'h9, 4'b1111, 3, 21'h1, 21'h2, 21'h9, 21'h0);

      repeat (3) @(negedge clk);
      chk("rst_pipe_ack", bus.pipe_ack_o, 0);
      chk("rst_busy", busy, 0);
      chk("rst_fml_stb", bus.fml_stb, 0);
      chk("rst_fill_stb", bus.fill_stb_o, 0);
      chk("rst_fml_adr", bus.fml_adr, 0);
      chk("rst_fill_adr", bus.fill_adr, 0);
      chk("rst_fill_dat", bus.fill_dat, 0);
      rst_n = 1'b1;
      #1;
      chk("rel_pipe_ack", bus.pipe_ack_o, 1);
      @(negedge clk);

      for (int i = 0; i < 7; i++) begin
         send_token(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].d, vecs[i].m);
         for (int j = 0; j < vecs[i].n; j++)
            do_burst(vecs[i].e[j], mk_beats(vecs[i].e[j]), 0, 0);
         check_idle("vec_end");
         @(negedge clk);
      end

      // Fill port stalled for 10 cycles.
      b4[0] = {4{16'h1111}}; b4[1] = {4{16'h2222}};
      b4[2] = {4{16'h3333}}; b4[3] = {4{16'h4444}};
      send_token(21'h0ABCD, 21'h0, 21'h0, 21'h0, 4'b0001);
      do_burst(21'h0ABCD, b4, 0, 10);
      check_idle("fill_stall");
      @(negedge clk);

      // FML request withheld for 7 cycles.
      send_token(21'h0, 21'h1F00, 21'h0, 21'h0, 4'b0010);
      do_burst(21'h1F00, mk_beats(21'h1F00), 7, 0);
      check_idle("fml_stall");
      @(negedge clk);

      // Reset asserted during beat 2.
      b4 = mk_beats(21'h33);
      send_token(21'h33, 21'h0, 21'h0, 21'h0, 4'b0001);
      chk("mid_fml_stb", bus.fml_stb, 1);
      bus.fml_ack = 1'b1;
      @(negedge clk);
      bus.fml_ack = 1'b0;
      bus.fml_di = b4[0];
      @(negedge clk);
      bus.fml_di = b4[1];
      @(negedge clk);
      bus.fml_di = b4[2];
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_pipe_ack", bus.pipe_ack_o, 0);
      chk("mid_rst_fml_stb", bus.fml_stb, 0);
      chk("mid_rst_fill_stb", bus.fill_stb_o, 0);
      chk("mid_rst_fml_adr", bus.fml_adr, 0);
      chk("mid_rst_fill_adr", bus.fill_adr, 0);
      chk("mid_rst_fill_dat", bus.fill_dat, 0);
      @(negedge clk);
      bus.fml_di = b4[3];
      @(negedge clk);
      rst_n = 1'b1;
      bus.fml_di = {4{16'hDEAD}};
      #1;
      chk("post_rst_pipe_ack", bus.pipe_ack_o, 1);
      @(negedge clk);
      bus.fml_di = '0;
      check_idle("post_rst");
      send_token(21'h44, 21'h0, 21'h0, 21'h0, 4'b0001);
      do_burst(21'h44, mk_beats(21'h44), 0, 0);
      check_idle("post_rst_tok");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
